// File: rtl/complement_sequencer_pkg.sv
// Shared types and constants for the byte-serial complement sequencer.
package comp_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic MODE_TWOS = 1'b0;
    localparam logic MODE_ONES = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/complement_sequencer_if.sv
// Operand/result handshake bundle for complement_sequencer.
// The ovf signal exists only when COMP_SEQ_OVF_EN is defined.
interface complement_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] in_data;
    logic             mode;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef COMP_SEQ_OVF_EN
    logic             ovf;

    modport master (
        output start_valid, in_data, mode, out_ready,
        input  start_ready, out_data, out_valid, busy, ovf
    );

    modport slave (
        input  start_valid, in_data, mode, out_ready,
        output start_ready, out_data, out_valid, busy, ovf
    );
`else
    modport master (
        output start_valid, in_data, mode, out_ready,
        input  start_ready, out_data, out_valid, busy
    );

    modport slave (
        input  start_valid, in_data, mode, out_ready,
        output start_ready, out_data, out_valid, busy
    );
`endif
endinterface

// File: rtl/comp_byte_slice.sv
// One byte of the complement datapath: inverts the byte and adds the
// incoming +1 carry; the carry survives only through an all-zero byte.
module comp_byte_slice
    import comp_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              cin,
    output logic [BYTE_W-1:0] byte_out,
    output logic              cout
);

    // Invert-and-increment plus carry propagation
    always_comb begin
        byte_out = ~byte_in + BYTE_W'(cin);
        cout     = cin & (byte_in == '0);
    end

endmodule

// File: rtl/complement_sequencer.sv
// Byte-serial two's/one's complement engine sharing one 8-bit slice across
// all operand bytes. Optional overflow flag enabled by COMP_SEQ_OVF_EN.
module complement_sequencer
    import comp_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    complement_sequencer_if.slave  bus
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t            state;
    logic [WIDTH-1:0]  op;
    logic [WIDTH-1:0]  result;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic              out_valid_r;
    logic              busy_r;
    logic              start_fire;
    logic [BYTE_W-1:0] op_byte;
    logic [BYTE_W-1:0] slice_out;
    logic              slice_cout;
`ifdef COMP_SEQ_OVF_EN
    logic              mode_r;
    logic              low_zero;
    logic              ovf_r;
`endif

    assign bus.start_ready = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
    assign start_fire      = bus.start_valid & bus.start_ready;
    assign op_byte         = op[idx*BYTE_W +: BYTE_W];

    comp_byte_slice u_slice (
        .byte_in  (op_byte),
        .cin      (carry),
        .byte_out (slice_out),
        .cout     (slice_cout)
    );

    // Sequencer FSM: capture, one byte per RUN cycle, hold result in DONE.
    // A start handshake is only possible in IDLE or in DONE with out_ready,
    // so it is handled ahead of the case and covers the back-to-back path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op          <= '0;
            result      <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef COMP_SEQ_OVF_EN
            mode_r      <= MODE_TWOS;
            low_zero    <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else if (start_fire) begin
            state       <= ST_RUN;
            op          <= bus.in_data;
            result      <= '0;
            idx         <= '0;
            carry       <= ~bus.mode;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b1;
`ifdef COMP_SEQ_OVF_EN
            mode_r      <= bus.mode;
            low_zero    <= 1'b1;
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    result[idx*BYTE_W +: BYTE_W] <= slice_out;
                    carry <= slice_cout;
                    idx   <= idx + 1'b1;
`ifdef COMP_SEQ_OVF_EN
                    low_zero <= low_zero & (op_byte == '0);
`endif
                    if (idx == IDXW'(NBYTES - 1)) begin
                        state       <= ST_DONE;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
`ifdef COMP_SEQ_OVF_EN
                        ovf_r <= (mode_r == MODE_TWOS) & low_zero &
                                 (op_byte == 8'h80);
`endif
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b0;
`ifdef COMP_SEQ_OVF_EN
                        ovf_r       <= 1'b0;
`endif
                    end
                end
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_data  = result;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
`ifdef COMP_SEQ_OVF_EN
    assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_complement_sequencer.sv
// Scoreboard bench for complement_sequencer; ovf checks with COMP_SEQ_OVF_EN.
module tb_complement_sequencer;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    complement_sequencer_if #(.WIDTH(32)) bus ();

    complement_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic m);
        exp_t e;
        e.data = m ? ~x : (~x + 32'd1);
        e.ovf  = (m == 1'b0) && (x == 32'h8000_0000);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) step();
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_op(input logic [31:0] d, input logic m);
        check("run_sready", {31'b0, bus.start_ready}, 32'd1);
        bus.in_data     = d;
        bus.mode        = m;
        bus.start_valid = 1'b1;
        sb.push_back(model(d, m));
        step();
        bus.start_valid = 1'b0;
        bus.in_data     = $urandom;
        bus.mode        = ~m;
        wait_drain(20);
    endtask

    // Result monitor: pop and compare on every output handshake
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", bus.out_data, e.data);
`ifdef COMP_SEQ_OVF_EN
                check("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
`endif
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.in_data     = '0;
        bus.mode        = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sready", {31'b0, bus.start_ready}, 32'd1);
        check("rst_valid",  {31'b0, bus.out_valid},   32'd0);
        check("rst_busy",   {31'b0, bus.busy},        32'd0);
        check("rst_data",   bus.out_data,             32'd0);
`ifdef COMP_SEQ_OVF_EN
        check("rst_ovf",    {31'b0, bus.ovf},         32'd0);
`endif
        rst = 1'b0;
        step();

        // Latency and busy window for 0x00000001
        bus.in_data     = 32'h0000_0001;
        bus.mode        = 1'b0;
        bus.start_valid = 1'b1;
        sb.push_back(model(32'h0000_0001, 1'b0));
        step();
        bus.start_valid = 1'b0;
        bus.in_data     = 32'hA5A5_A5A5;
        for (int k = 0; k < 4; k++) begin
            check("lat_busy",  {31'b0, bus.busy},      32'd1);
            check("lat_valid", {31'b0, bus.out_valid}, 32'd0);
            step();
        end
        check("lat_valid_up", {31'b0, bus.out_valid}, 32'd1);
        check("lat_busy_dn",  {31'b0, bus.busy},      32'd0);
        check("lat_data",     bus.out_data,           32'hFFFF_FFFF);
        step();
        check("lat_valid_dn", {31'b0, bus.out_valid}, 32'd0);

        // Carry ripple patterns
        run_op(32'h0000_0000, 1'b0);
        run_op(32'h0000_0100, 1'b0);
        run_op(32'h0F0F_0F0F, 1'b1);
        run_op(32'hFFFF_FFFF, 1'b0);

        // Backpressure then back-to-back issue in DONE
        bus.out_ready   = 1'b0;
        bus.in_data     = 32'h1234_5678;
        bus.mode        = 1'b0;
        bus.start_valid = 1'b1;
        sb.push_back(model(32'h1234_5678, 1'b0));
        step();
        bus.start_valid = 1'b0;
        for (int k = 0; k < 10 && !bus.out_valid; k++) step();
        check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_data", bus.out_data,             32'hEDCB_A988);
            check("bp_sready",    {31'b0, bus.start_ready}, 32'd0);
            check("bp_hold_vld",  {31'b0, bus.out_valid},   32'd1);
            step();
        end
        bus.out_ready   = 1'b1;
        bus.in_data     = 32'h0000_0005;
        bus.mode        = 1'b0;
        bus.start_valid = 1'b1;
        sb.push_back(model(32'h0000_0005, 1'b0));
        #1;
        check("b2b_sready", {31'b0, bus.start_ready}, 32'd1);
        step();
        bus.start_valid = 1'b0;
        check("b2b_valid_dn", {31'b0, bus.out_valid}, 32'd0);
        check("b2b_busy",     {31'b0, bus.busy},      32'd1);
        repeat (3) step();
        check("b2b_not_yet", {31'b0, bus.out_valid}, 32'd0);
        step();
        check("b2b_valid_up", {31'b0, bus.out_valid}, 32'd1);
        check("b2b_data",     bus.out_data,           32'hFFFF_FFFB);
        wait_drain(5);

        // Asynchronous reset two cycles into RUN
        bus.in_data     = 32'hCAFE_F00D;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        step();
        step();
        check("pre_abort_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_valid",  {31'b0, bus.out_valid},   32'd0);
        check("abort_busy",   {31'b0, bus.busy},        32'd0);
        check("abort_sready", {31'b0, bus.start_ready}, 32'd1);
        check("abort_data",   bus.out_data,             32'd0);
        step();
        rst = 1'b0;
        repeat (8) step();
        check("abort_no_out", {31'b0, bus.out_valid}, 32'd0);

        // start_valid during RUN is ignored
        bus.in_data     = 32'h1111_1111;
        bus.mode        = 1'b0;
        bus.start_valid = 1'b1;
        sb.push_back(model(32'h1111_1111, 1'b0));
        step();
        bus.start_valid = 1'b0;
        step();
        bus.in_data     = 32'hDEAD_BEEF;
        bus.mode        = 1'b1;
        bus.start_valid = 1'b1;
        check("run_sready", {31'b0, bus.start_ready}, 32'd0);
        step();
        bus.start_valid = 1'b0;
        wait_drain(20);
        repeat (8) step();
        check("ign_idle", {31'b0, bus.busy}, 32'd0);

`ifdef COMP_SEQ_OVF_EN
        run_op(32'h8000_0000, 1'b0);
        run_op(32'h7FFF_FFFF, 1'b0);
        run_op(32'h8000_0000, 1'b1);
        step();
        check("ovf_cleared", {31'b0, bus.ovf}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
